// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat match-level sequencer.
// Light codes are {player_win_light, dealer_win_light}.
package baccarat_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        PLAY,
        RESULT,
        WAIT,
        DONE
    } rc_state_t;

    typedef enum logic [1:0] {
        NONE   = 2'b00,
        PLAYER = 2'b01,
        DEALER = 2'b10,
        DRAWN  = 2'b11
    } match_result_t;

    localparam logic [1:0] LIGHT_PLAYER = 2'b10;
    localparam logic [1:0] LIGHT_DEALER = 2'b01;
    localparam logic [1:0] LIGHT_TIE    = 2'b11;

    localparam int COUNT_W = 4;

    // A faulted match has no winner, whatever the tallies say.
    function automatic match_result_t decide_winner(
        input logic [COUNT_W-1:0] pwins,
        input logic [COUNT_W-1:0] dwins,
        input logic               faulted
    );
        if (faulted)
            return NONE;
        else if (pwins > dwins)
            return PLAYER;
        else if (dwins > pwins)
            return DEALER;
        else
            return DRAWN;
    endfunction

endpackage

// File: rtl/round_controller_rise_detect.sv
// Rising-edge detector for the debounced deal button.
// press is combinational from level; the level register clears on reset.
module rise_detect (
    input  logic slow_clock,
    input  logic resetb,
    input  logic level,
    output logic press
);

    logic level_q;

    // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb)
            level_q <= 1'b0;
        else
            level_q <= level;
    end

    assign press = level & ~level_q;

endmodule

// File: rtl/round_controller.sv
// Match-level sequencer: turns button presses into game advance pulses,
// resets the game between rounds, tallies outcomes and decides the match.
module round_controller
    import baccarat_pkg::*;
#(
    parameter int ROUNDS    = 5,
    parameter int MAX_STEPS = 8
) (
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic               deal_req,
    input  logic               player_win_light,
    input  logic               dealer_win_light,
    output logic               game_resetb,
    output logic               advance,
    output logic [COUNT_W-1:0] pwins,
    output logic [COUNT_W-1:0] dwins,
    output logic [COUNT_W-1:0] ties,
    output logic [COUNT_W-1:0] rounds_played,
    output logic               match_over,
    output logic [1:0]         match_winner,
    output logic               fault
);

    localparam int STEP_W = $clog2(MAX_STEPS + 1);
    localparam logic [STEP_W-1:0]  STEP_LIMIT   = STEP_W'(MAX_STEPS);
    localparam logic [COUNT_W-1:0] WIN_TARGET   = COUNT_W'((ROUNDS + 1) / 2);
    localparam logic [COUNT_W-1:0] ROUNDS_LIMIT = COUNT_W'(ROUNDS);

    logic press;

    rise_detect u_rise_detect (
        .slow_clock (slow_clock),
        .resetb     (resetb),
        .level      (deal_req),
        .press      (press)
    );

    rc_state_t           state_q,    state_d;
    logic [STEP_W-1:0]   step_cnt_q, step_cnt_d;
    logic [1:0]          light_q,    light_d;
    logic [COUNT_W-1:0]  pwins_q,    pwins_d;
    logic [COUNT_W-1:0]  dwins_q,    dwins_d;
    logic [COUNT_W-1:0]  ties_q,     ties_d;
    logic [COUNT_W-1:0]  rounds_q,   rounds_d;
    logic                advance_q,  advance_d;
    logic                game_rst_q, game_rst_d;
    logic                over_q,     over_d;
    logic                fault_q,    fault_d;
    match_result_t       winner_q,   winner_d;
    logic [1:0]          lights;

    assign lights = {player_win_light, dealer_win_light};

    always_comb begin
        // NOTE: every signal written here gets a default first so no latch can be inferred.
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        light_d    = light_q;
        pwins_d    = pwins_q;
        dwins_d    = dwins_q;
        ties_d     = ties_q;
        rounds_d   = rounds_q;
        fault_d    = fault_q;
        advance_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (press)
                    state_d = CLEAR;
            end
            CLEAR: begin
                step_cnt_d = '0;
                state_d    = PLAY;
            end
            PLAY: begin
                // A lit outcome beats a simultaneous press; the step budget is checked next.
                if (lights != 2'b00) begin
                    light_d = lights;
                    state_d = RESULT;
                end else if (step_cnt_q == STEP_LIMIT) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end else if (press) begin
                    advance_d  = 1'b1;
                    step_cnt_d = step_cnt_q + 1'b1;
                end
            end
            RESULT: begin
                unique case (light_q)
                    LIGHT_PLAYER: pwins_d = pwins_q + 1'b1;
                    LIGHT_DEALER: dwins_d = dwins_q + 1'b1;
                    LIGHT_TIE:    ties_d  = ties_q + 1'b1;
                    default:      ;
                endcase
                rounds_d = rounds_q + 1'b1;
                if (pwins_d >= WIN_TARGET || dwins_d >= WIN_TARGET || rounds_d >= ROUNDS_LIMIT)
                    state_d = DONE;
                else
                    state_d = WAIT;
            end
            WAIT: begin
                if (press)
                    state_d = CLEAR;
            end
            DONE: ;
            default: state_d = IDLE;
        endcase

        // Outputs are registered copies of what the next state implies.
        game_rst_d = (state_d != IDLE) && (state_d != CLEAR);
        over_d     = (state_d == DONE);
        winner_d   = over_d ? decide_winner(pwins_d, dwins_d, fault_d) : NONE;
    end

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            step_cnt_q <= '0;
            light_q    <= 2'b00;
            pwins_q    <= '0;
            dwins_q    <= '0;
            ties_q     <= '0;
            rounds_q   <= '0;
            advance_q  <= 1'b0;
            game_rst_q <= 1'b0;
            over_q     <= 1'b0;
            fault_q    <= 1'b0;
            winner_q   <= NONE;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            light_q    <= light_d;
            pwins_q    <= pwins_d;
            dwins_q    <= dwins_d;
            ties_q     <= ties_d;
            rounds_q   <= rounds_d;
            advance_q  <= advance_d;
            game_rst_q <= game_rst_d;
            over_q     <= over_d;
            fault_q    <= fault_d;
            winner_q   <= winner_d;
        end
    end

    assign game_resetb   = game_rst_q;
    assign advance       = advance_q;
    assign pwins         = pwins_q;
    assign dwins         = dwins_q;
    assign ties          = ties_q;
    assign rounds_played = rounds_q;
    assign match_over    = over_q;
    assign match_winner  = winner_q;
    assign fault         = fault_q;

endmodule
